// File: rtl/cnn_pkg.sv
// Shared widths, write-select codes and sequencer states for the CNN stream driver.
// Purpose: common types for cnn_stream_driver and cnn_elem_buf.
// Ports: none (package).
package cnn_pkg;

  localparam int IMG_W = 4;
  localparam int F1_W  = 4;
  localparam int F2_W  = 10;
  localparam int RES_W = 22;

  // Element buffers are 16 deep and addressed by a 4-bit index.
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  // Sequencer counter width; wide enough for element counts and wait lengths.
  localparam int CW    = 8;

  localparam logic [1:0] SEL_IMG  = 2'd0;
  localparam logic [1:0] SEL_F1   = 2'd1;
  localparam logic [1:0] SEL_F2   = 2'd2;
  localparam logic [1:0] SEL_NONE = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_L1_STR,
    ST_L1_GAP,
    ST_L1_RD,
    ST_L2_STR,
    ST_L2_GAP,
    ST_L2_RD
  } st_e;

endpackage

// File: rtl/cnn_elem_buf.sv
// Purpose: 16-deep element store, one write port, combinational read by index.
// Latency: write visible on the read port the cycle after the write edge; read is async.
// Backpressure: none; every write strobe is taken.
// Ports: clk/rst_n (async clear to 0), we/waddr/wdata write port, raddr -> rdata read.
module cnn_elem_buf
  import cnn_pkg::*;
#(
  parameter int W = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/cnn_stream_driver.sv
// Purpose: holds one image/filter set and, on go, replays the Layer-1/Layer-2 stream into CNN_Two_Layer, then captures ConvResult.
// Latency: core-facing outputs lag the sequencer state by one cycle; done fires N1+N2+L1_WAIT+RD_WAIT+2 cycles after go.
// Backpressure: none; go and buffer writes are ignored while busy, nothing is queued.
// Ports: host side wr_en/wr_sel/wr_addr/wr_data, go, busy, done, result;
//        core side Start1/Image/Filter1/ReadEn1, Start2/Filter2/ReadEn2, ConvResult.
// Optional: CNN_STREAM_DRIVER_CHECK_EN adds exp_result input and mismatch output.
module cnn_stream_driver
  import cnn_pkg::*;
#(
  parameter int N1      = 15,
  parameter int N2      = 15,
  parameter int L1_WAIT = 2,
  parameter int RD_WAIT = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic [1:0]              wr_sel,
  input  logic [3:0]              wr_addr,
  input  logic [9:0]              wr_data,
  input  logic                    go,
  output logic                    busy,
  output logic                    done,
  output logic signed [RES_W-1:0] result,
  output logic                    Start1,
  output logic [IMG_W-1:0]        Image,
  output logic signed [F1_W-1:0]  Filter1,
  output logic                    ReadEn1,
  output logic                    Start2,
  output logic signed [F2_W-1:0]  Filter2,
  output logic                    ReadEn2,
  input  logic signed [RES_W-1:0] ConvResult
`ifdef CNN_STREAM_DRIVER_CHECK_EN
  ,
  input  logic [RES_W-1:0]        exp_result,
  output logic                    mismatch
`endif
);

  st_e           state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          capture;

  logic [IMG_W-1:0] img_rd;
  logic [F1_W-1:0]  f1_rd;
  logic [F2_W-1:0]  f2_rd;

  logic img_we, f1_we, f2_we;
  logic wr_ok;

  logic             start1_d, readen1_d, start2_d, readen2_d;
  logic [IMG_W-1:0] image_d;
  logic [F1_W-1:0]  filter1_d;
  logic [F2_W-1:0]  filter2_d;

  // ---------------- buffer write decode ----------------
  // Writes only land while idle; an index past the buffer's element count is dropped.
  assign wr_ok = wr_en && (state == ST_IDLE);

  always_comb begin
    img_we = 1'b0;
    f1_we  = 1'b0;
    f2_we  = 1'b0;
    case (wr_sel)
      SEL_IMG:  img_we = wr_ok && ({1'b0, wr_addr} < 5'(N1));
      SEL_F1:   f1_we  = wr_ok && ({1'b0, wr_addr} < 5'(N1));
      SEL_F2:   f2_we  = wr_ok && ({1'b0, wr_addr} < 5'(N2));
      SEL_NONE: ;
      default:  ;
    endcase
  end

  cnn_elem_buf #(.W(IMG_W)) u_img_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (img_we),
    .waddr (wr_addr),
    .wdata (wr_data[IMG_W-1:0]),
    .raddr (cnt[AW-1:0]),
    .rdata (img_rd)
  );

  cnn_elem_buf #(.W(F1_W)) u_f1_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (f1_we),
    .waddr (wr_addr),
    .wdata (wr_data[F1_W-1:0]),
    .raddr (cnt[AW-1:0]),
    .rdata (f1_rd)
  );

  cnn_elem_buf #(.W(F2_W)) u_f2_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (f2_we),
    .waddr (wr_addr),
    .wdata (wr_data),
    .raddr (cnt[AW-1:0]),
    .rdata (f2_rd)
  );

  // ---------------- sequencer ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // One counter is reused by every timed phase; it restarts at 0 on each phase change.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 1'b1;
    capture   = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_nxt = '0;
        if (go) state_nxt = ST_L1_STR;
      end
      ST_L1_STR: begin
        if (cnt == CW'(N1 - 1)) begin
          state_nxt = ST_L1_GAP;
          cnt_nxt   = '0;
        end
      end
      ST_L1_GAP: begin
        state_nxt = ST_L1_RD;
        cnt_nxt   = '0;
      end
      ST_L1_RD: begin
        if (cnt == CW'(L1_WAIT - 1)) begin
          state_nxt = ST_L2_STR;
          cnt_nxt   = '0;
        end
      end
      ST_L2_STR: begin
        if (cnt == CW'(N2 - 1)) begin
          state_nxt = ST_L2_GAP;
          cnt_nxt   = '0;
        end
      end
      ST_L2_GAP: begin
        state_nxt = ST_L2_RD;
        cnt_nxt   = '0;
      end
      ST_L2_RD: begin
        if (cnt == CW'(RD_WAIT - 1)) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
          capture   = 1'b1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Core-facing values for the current state; registered below, so the core
  // sees each phase one cycle after the sequencer enters it.
  always_comb begin
    start1_d  = 1'b0;
    image_d   = '0;
    filter1_d = '0;
    start2_d  = 1'b0;
    filter2_d = '0;
    readen2_d = 1'b0;
    // ReadEn1 holds from the Layer-1 read phase until the sequence ends.
    readen1_d = (state == ST_L1_RD)  || (state == ST_L2_STR) ||
                (state == ST_L2_GAP) || (state == ST_L2_RD);
    case (state)
      ST_L1_STR: begin
        start1_d  = 1'b1;
        image_d   = img_rd;
        filter1_d = f1_rd;
      end
      ST_L2_STR: begin
        start2_d  = 1'b1;
        filter2_d = f2_rd;
      end
      ST_L2_RD:  readen2_d = 1'b1;
      default:   ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Start1  <= 1'b0;
      Image   <= '0;
      Filter1 <= '0;
      ReadEn1 <= 1'b0;
      Start2  <= 1'b0;
      Filter2 <= '0;
      ReadEn2 <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
    end else begin
      Start1  <= start1_d;
      Image   <= image_d;
      Filter1 <= filter1_d;
      ReadEn1 <= readen1_d;
      Start2  <= start2_d;
      Filter2 <= filter2_d;
      ReadEn2 <= readen2_d;
      done    <= capture;
      if (capture) result <= ConvResult;
    end
  end

  assign busy = (state != ST_IDLE);

`ifdef CNN_STREAM_DRIVER_CHECK_EN
  // Sticky compare flag: set on the capture cycle, cleared when a new sequence starts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mismatch <= 1'b0;
    end else if (capture) begin
      mismatch <= ($unsigned(ConvResult) != exp_result);
    end else if (go && (state == ST_IDLE)) begin
      mismatch <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_cnn_stream_driver.sv
module tb_cnn_stream_driver;

  localparam int N1 = 15;
  localparam int N2 = 15;
  localparam int LW = 2;
  localparam int RW = 4;
  localparam int BUSY_LEN = N1 + N2 + LW + RW + 2;  // 38
  localparam int L2_FIRST = N1 + 2 + LW;            // 19
  localparam int R2_FIRST = N1 + LW + N2 + 3;       // 35
  localparam int LAST_E   = BUSY_LEN + 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              wr_en = 1'b0;
  logic [1:0]        wr_sel = 2'd0;
  logic [3:0]        wr_addr = 4'd0;
  logic [9:0]        wr_data = 10'd0;
  logic              go = 1'b0;
  logic              busy, done;
  logic signed [21:0] result;
  logic              Start1, ReadEn1, Start2, ReadEn2;
  logic [3:0]        Image;
  logic signed [3:0] Filter1;
  logic signed [9:0] Filter2;
  logic signed [21:0] ConvResult;
`ifdef CNN_STREAM_DRIVER_CHECK_EN
  logic [21:0]       exp_result = 22'd0;
  logic              mismatch;
`endif

  always #5 clk = ~clk;

  // Core model: answers -10 while it is being read.
  assign ConvResult = ReadEn2 ? -22'sd10 : 22'sd0;

  cnn_stream_driver #(.N1(N1), .N2(N2), .L1_WAIT(LW), .RD_WAIT(RW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_sel     (wr_sel),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .go         (go),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .Start1     (Start1),
    .Image      (Image),
    .Filter1    (Filter1),
    .ReadEn1    (ReadEn1),
    .Start2     (Start2),
    .Filter2    (Filter2),
    .ReadEn2    (ReadEn2),
    .ConvResult (ConvResult)
`ifdef CNN_STREAM_DRIVER_CHECK_EN
    ,
    .exp_result (exp_result),
    .mismatch   (mismatch)
`endif
  );

  typedef struct packed {
    logic       s1;
    logic [3:0] img;
    logic [3:0] f1;
    logic       r1;
    logic       s2;
    logic [9:0] f2;
    logic       r2;
    logic       bsy;
    logic       dn;
  } exp_t;

  exp_t tbl [0:LAST_E];

  int img_i [N1] = '{1, 2, 3, 2, 3, 4, 3, 4, 5, 4, 5, 6, 5, 6, 7};
  int f1_i  [N1] = '{1, 2, 3, -3, -2, -1, 1, 2, 3, -5, 5, -7, 1, 2, 3};
  int f2_i  [N2] = '{1, 2, 3, -1, -2, -3, 4, 5, 6, -4, -5, -6, 7, 8, 9};
  logic [3:0] img_v [N1];
  logic [3:0] f1_v  [N1];
  logic [9:0] f2_v  [N2];

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t actual();
    exp_t a;
    a.s1 = Start1; a.img = Image; a.f1 = Filter1; a.r1 = ReadEn1;
    a.s2 = Start2; a.f2 = Filter2; a.r2 = ReadEn2; a.bsy = busy; a.dn = done;
    return a;
  endfunction

  // Expected outputs sampled just after edge e, where go is taken at edge 0.
  task automatic build_tbl();
    for (int e = 0; e <= LAST_E; e++) begin
      exp_t t;
      t = '0;
      t.bsy = (e < BUSY_LEN);
      t.dn  = (e == BUSY_LEN);
      if (e >= 1 && e <= N1) begin
        t.s1  = 1'b1;
        t.img = img_v[e-1];
        t.f1  = f1_v[e-1];
      end
      t.r1 = (e >= N1 + 2) && (e <= BUSY_LEN);
      if (e >= L2_FIRST && e < L2_FIRST + N2) begin
        t.s2 = 1'b1;
        t.f2 = f2_v[e-L2_FIRST];
      end
      t.r2 = (e >= R2_FIRST) && (e <= BUSY_LEN);
      tbl[e] = t;
    end
  endtask

  task automatic wr(input logic [1:0] s, input logic [3:0] a, input logic [9:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_sel = s; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic load_all();
    for (int i = 0; i < N1; i++) wr(2'd0, 4'(i), {6'd0, img_v[i]});
    for (int i = 0; i < N1; i++) wr(2'd1, 4'(i), {6'd0, f1_v[i]});
    for (int i = 0; i < N2; i++) wr(2'd2, 4'(i), f2_v[i]);
  endtask

  // mode 0: plain run; mode 1: go and a write mid-run (both ignored);
  // mode 2: an image[0] write in the same cycle as go (must be used).
  task automatic run_seq(input int mode, input string tag);
    @(negedge clk);
    go = 1'b1;
    if (mode == 2) begin
      wr_en = 1'b1; wr_sel = 2'd0; wr_addr = 4'd0; wr_data = 10'd9;
      img_v[0] = 4'd9;
    end
    build_tbl();
    @(posedge clk);
    #1;
    go = 1'b0;
    wr_en = 1'b0;
    chk($sformatf("%s e0", tag), 64'(actual()), 64'(tbl[0]));
    for (int e = 1; e <= LAST_E; e++) begin
      @(posedge clk);
      #1;
      chk($sformatf("%s e%0d", tag, e), 64'(actual()), 64'(tbl[e]));
      if (e == BUSY_LEN)
        chk($sformatf("%s result", tag), {42'd0, result}, {42'd0, 22'h3FFFF6});
      if (mode == 1) begin
        if (e == 5) begin
          wr_en = 1'b1; wr_sel = 2'd0; wr_addr = 4'd14; wr_data = 10'd0;
        end
        if (e == 6) wr_en = 1'b0;
        if (e == 20) go = 1'b1;
        if (e == 21) go = 1'b0;
      end
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {18'd0, Start1, Image, Filter1, ReadEn1, Start2, Filter2, ReadEn2,
            busy, done, result};
  endfunction

  initial begin
    for (int i = 0; i < N1; i++) begin
      img_v[i] = 4'(img_i[i]);
      f1_v[i]  = 4'(f1_i[i]);
    end
    for (int i = 0; i < N2; i++) f2_v[i] = 10'(f2_i[i]);

    // Reset state
    #12;
    chk("reset outs", all_outs(), 64'd0);
`ifdef CNN_STREAM_DRIVER_CHECK_EN
    chk("reset mismatch", {63'd0, mismatch}, 64'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Load, plus a write with select 3 that must not land anywhere.
    load_all();
    wr(2'd3, 4'd0, 10'h3FF);
`ifdef CNN_STREAM_DRIVER_CHECK_EN
    exp_result = 22'd5;
`endif
    run_seq(0, "run1");
`ifdef CNN_STREAM_DRIVER_CHECK_EN
    chk("mismatch set", {63'd0, mismatch}, 64'd1);
    exp_result = 22'h3FFFF6;
`endif

    // Mid-sequence go and write are ignored.
    run_seq(1, "ign");
`ifdef CNN_STREAM_DRIVER_CHECK_EN
    chk("mismatch clear", {63'd0, mismatch}, 64'd0);
`endif

    // Reset during Layer-2 streaming.
    @(negedge clk);
    go = 1'b1;
    @(posedge clk);
    #1 go = 1'b0;
    for (int i = 0; i < 25; i++) @(posedge clk);
    #1;
    chk("pre-reset start2", {63'd0, Start2}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset outs", all_outs(), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Buffers cleared by reset: first streamed pair is zero.
    @(negedge clk);
    go = 1'b1;
    @(posedge clk);
    #1 go = 1'b0;
    @(posedge clk);
    #1;
    chk("cleared elem0", {55'd0, Start1, Image, Filter1}, {55'd0, 1'b1, 8'd0});
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Reload and rerun, with a write coinciding with go.
    load_all();
    run_seq(2, "gowr");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
